// File: rtl/inst_fetch_queue_pkg.sv
//==============================================================================
// Module  : inst_fetch_queue_pkg
// Purpose : Shared bus/enable defines and elaboration helpers for the
//           instruction-fetch queue (inst_fetch_queue, if_queue_ram).
// Ports   : none (package)
// Rev     : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps

`ifndef IFQ_SHARED_DEFINES
`define IFQ_SHARED_DEFINES
`define InstAddrBus 31:0
`define InstBus     31:0
`define ChipEnable  1'b1
`define ChipDisable 1'b0
`define RstnEnable  1'b0
`define ZeroWord    32'h00000000
`endif

`default_nettype none

package inst_fetch_queue_pkg;

  localparam int unsigned IFQ_DEPTH_DEF  = 4;
  localparam int unsigned IFQ_ADDR_W_DEF = 32;
  localparam int unsigned IFQ_DATA_W_DEF = 32;

  // Pointer width for a power-of-two queue; never below one bit.
  function automatic int unsigned ifq_ptr_w(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_queue_ram.sv
//==============================================================================
// Module  : if_queue_ram
// Purpose : DEPTH x WIDTH register array holding {pc, inst} queue entries.
//           One synchronous write port, asynchronous read at raddr.
// Ports   : clk, rst (async active-low), we/waddr/wdata write port,
//           raddr/rdata read port.
// Rev     : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module if_queue_ram
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IFQ_DEPTH_DEF,
  parameter int unsigned WIDTH = IFQ_ADDR_W_DEF + IFQ_DATA_W_DEF,
  parameter int unsigned PTR_W = ifq_ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (rst == `RstnEnable) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/inst_fetch_queue.sv
//==============================================================================
// Module  : inst_fetch_queue
// Purpose : IF stage between PC register and ID. Issues ROM reads for the PC
//           stage's fetch address, buffers returning {pc, inst} pairs in an
//           in-order queue, and hands them to ID with a valid/stall handshake.
//           Back-pressures the PC stage when queue credit is exhausted and
//           discards queued and in-flight fetches on flush.
// Ports   : clk, rst (async active-low)
//           pc_i, ce_i, pc_stall_o          - PC stage side
//           rom_ce_o, rom_addr_o, rom_data_i - instruction ROM (1-cycle read)
//           id_stall_i, id_valid_o, id_pc_o, id_inst_o - ID stage side
//           flush_i                          - synchronous pipeline flush
// Rev     : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = IFQ_DEPTH_DEF,
  parameter int unsigned ADDR_W = IFQ_ADDR_W_DEF,
  parameter int unsigned DATA_W = IFQ_DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  output logic              pc_stall_o,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  input  logic              id_stall_i,
  input  logic              flush_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [DATA_W-1:0] id_inst_o
);

  localparam int unsigned PTR_W = ifq_ptr_w(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;

  logic              w_run;
  logic              w_fetch;
  logic [CNT_W-1:0]  w_used;
  logic              w_space;
  logic              w_valid;
  logic              w_push;
  logic              w_pop;
  logic [ENT_W-1:0]  w_head;
  logic [ADDR_W-1:0] w_head_pc;
  logic [DATA_W-1:0] w_head_inst;

  // Every output is held at zero while reset is asserted, including the
  // purely combinational issue/stall paths.
  assign w_run   = (rst != `RstnEnable);
  assign w_fetch = (ce_i == `ChipEnable);

  // An in-flight read already owns a slot, so credit counts it. No pop
  // lookahead: the PC-side stall never depends on id_stall_i.
  assign w_used  = r_count + CNT_W'(r_inflight);
  assign w_space = (w_used < c_DEPTH);

  assign rom_ce_o   = w_run & w_fetch &  w_space & ~flush_i;
  assign pc_stall_o = w_run & w_fetch & ~w_space & ~flush_i;
  assign rom_addr_o = w_run ? pc_i : '0;

  assign w_valid = w_run & (r_count != '0) & ~flush_i;
  assign w_push  = r_inflight & ~flush_i;
  assign w_pop   = w_valid & ~id_stall_i;

  if_queue_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (w_push),
    .waddr (r_wr_ptr),
    .wdata ({r_inflight_pc, rom_data_i}),
    .raddr (r_rd_ptr),
    .rdata (w_head)
  );

  assign w_head_pc   = w_head[ENT_W-1:DATA_W];
  assign w_head_inst = w_head[DATA_W-1:0];

  assign id_valid_o = w_valid;
  assign id_pc_o    = w_valid ? w_head_pc   : '0;
  assign id_inst_o  = w_valid ? w_head_inst : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == `RstnEnable) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (flush_i) begin
      // Dropping inflight here is what discards the ROM word that lands
      // on the next cycle.
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= rom_ce_o;
      if (rom_ce_o) begin
        r_inflight_pc <= pc_i;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`timescale 1ns/1ps

module tb_inst_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] KEY   = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_i = '0;
  logic        ce_i = 1'b0;
  logic        id_stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] rom_data_i = '0;
  logic        pc_stall_o, rom_ce_o, id_valid_o;
  logic [31:0] rom_addr_o, id_pc_o, id_inst_o;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_i       (pc_i),
    .ce_i       (ce_i),
    .pc_stall_o (pc_stall_o),
    .rom_ce_o   (rom_ce_o),
    .rom_addr_o (rom_addr_o),
    .rom_data_i (rom_data_i),
    .id_stall_i (id_stall_i),
    .flush_i    (flush_i),
    .id_valid_o (id_valid_o),
    .id_pc_o    (id_pc_o),
    .id_inst_o  (id_inst_o)
  );

  // Synchronous ROM: word = address ^ KEY one cycle after a read, junk otherwise.
  always @(posedge clk) rom_data_i <= rom_ce_o ? (rom_addr_o ^ KEY) : 32'hDEADBEEF;

  // Reference model: in-order queue of fetched pairs plus one pending read.
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        q[$];
  bit          m_inf = 1'b0;
  logic [31:0] m_inf_pc = '0;

  int checks = 0;
  int failures = 0;
  bit          e_valid, e_ce, e_stall;
  logic [31:0] e_pc, e_inst, e_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs after the falling edge, then compare against the model.
  task automatic drive(input bit r, input bit ce, input logic [31:0] pc,
                       input bit st, input bit fl);
    int used;
    @(negedge clk);
    rst = r; ce_i = ce; pc_i = pc; id_stall_i = st; flush_i = fl;
    #1;
    if (!r) begin
      e_valid = 0; e_ce = 0; e_stall = 0; e_pc = '0; e_inst = '0; e_addr = '0;
    end else begin
      used    = q.size() + int'(m_inf);
      e_ce    = ce && (used < DEPTH) && !fl;
      e_stall = ce && (used >= DEPTH) && !fl;
      e_valid = (q.size() != 0) && !fl;
      e_pc    = e_valid ? q[0].pc   : '0;
      e_inst  = e_valid ? q[0].inst : '0;
      e_addr  = pc;
    end
    chk("id_valid", 32'(id_valid_o), 32'(e_valid));
    chk("id_pc",    id_pc_o,          e_pc);
    chk("id_inst",  id_inst_o,        e_inst);
    chk("rom_ce",   32'(rom_ce_o),    32'(e_ce));
    chk("pc_stall", 32'(pc_stall_o),  32'(e_stall));
    chk("rom_addr", rom_addr_o,       e_addr);
  endtask

  // Move the model across the rising edge using the inputs held this cycle.
  task automatic advance();
    @(posedge clk);
    if (!rst) begin
      q.delete(); m_inf = 0; m_inf_pc = '0;
    end else if (flush_i) begin
      q.delete(); m_inf = 0;
    end else begin
      if (e_valid && !id_stall_i) void'(q.pop_front());
      if (m_inf) q.push_back('{m_inf_pc, m_inf_pc ^ KEY});
      m_inf = e_ce;
      if (e_ce) m_inf_pc = pc_i;
    end
  endtask

  task automatic step(input bit r, input bit ce, input logic [31:0] pc,
                      input bit st, input bit fl);
    drive(r, ce, pc, st, fl);
    advance();
  endtask

  typedef struct { bit ce; logic [31:0] pc; bit ev; logic [31:0] epc; bit ece; } vec_t;
  vec_t tab[14];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] pc;
    logic [31:0] exp_next;

    // Streaming then ce toggling: {ce, pc, exp_valid, exp_id_pc, exp_rom_ce}
    tab[0]  = '{1, 32'h00, 0, 32'h00, 1};
    tab[1]  = '{1, 32'h04, 0, 32'h00, 1};
    tab[2]  = '{1, 32'h08, 1, 32'h00, 1};
    tab[3]  = '{1, 32'h0C, 1, 32'h04, 1};
    tab[4]  = '{1, 32'h10, 1, 32'h08, 1};
    tab[5]  = '{0, 32'h14, 1, 32'h0C, 0};
    tab[6]  = '{0, 32'h14, 1, 32'h10, 0};
    tab[7]  = '{0, 32'h14, 0, 32'h00, 0};
    tab[8]  = '{1, 32'h20, 0, 32'h00, 1};
    tab[9]  = '{0, 32'h20, 0, 32'h00, 0};
    tab[10] = '{1, 32'h24, 1, 32'h20, 1};
    tab[11] = '{0, 32'h24, 0, 32'h00, 0};
    tab[12] = '{0, 32'h24, 1, 32'h24, 0};
    tab[13] = '{0, 32'h24, 0, 32'h00, 0};

    step(0, 1, 32'h0, 0, 0);
    step(0, 1, 32'h0, 0, 0);

    for (int i = 0; i < 14; i++) begin
      drive(1, tab[i].ce, tab[i].pc, 0, 0);
      chk("tab_valid", 32'(id_valid_o), 32'(tab[i].ev));
      chk("tab_pc",    id_pc_o,         tab[i].epc);
      chk("tab_inst",  id_inst_o,       tab[i].ev ? (tab[i].epc ^ KEY) : 32'h0);
      chk("tab_romce", 32'(rom_ce_o),   32'(tab[i].ece));
      chk("tab_stall", 32'(pc_stall_o), 32'h0);
      advance();
    end

    // Fill with ID stalled: four accepted requests, then back-pressure.
    pc = 32'h30;
    for (int k = 0; k < 4; k++) begin
      step(1, 1, pc, 1, 0);
      if (e_ce) pc += 4;
    end
    drive(1, 1, pc, 1, 0);
    chk("full_stall", 32'(pc_stall_o), 32'h1);
    chk("full_romce", 32'(rom_ce_o),   32'h0);
    advance();

    // Drain in order, fetching resumes with no loss or duplicates.
    exp_next = 32'h30;
    for (int k = 0; k < 10; k++) begin
      drive(1, 1, pc, 0, 0);
      if (id_valid_o) begin
        chk("drain_order", id_pc_o, exp_next);
        exp_next += 4;
      end
      advance();
      if (e_ce) pc += 4;
    end

    // Keep it near full with ID stall toggling every cycle.
    for (int k = 0; k < 24; k++) begin
      drive(1, 1, pc, k[0], 0);
      if (id_valid_o) begin
        chk("alt_order", id_pc_o, exp_next);
        if (!k[0]) exp_next += 4;
      end
      advance();
      if (e_ce) pc += 4;
    end

    // Flush with two queued entries and one in flight.
    repeat (6) step(1, 0, 32'h0, 0, 0);
    step(1, 1, 32'h40, 1, 0);
    step(1, 1, 32'h44, 1, 0);
    step(1, 1, 32'h48, 1, 0);
    drive(1, 1, 32'h4C, 1, 1);
    chk("flush_valid", 32'(id_valid_o), 32'h0);
    chk("flush_romce", 32'(rom_ce_o),   32'h0);
    advance();
    drive(1, 1, 32'h100, 0, 0);
    chk("post_flush_valid", 32'(id_valid_o), 32'h0);
    chk("post_flush_romce", 32'(rom_ce_o),   32'h1);
    advance();
    drive(1, 1, 32'h104, 0, 0);
    chk("post_flush_valid2", 32'(id_valid_o), 32'h0);
    advance();
    drive(1, 1, 32'h108, 0, 0);
    chk("post_flush_first", id_pc_o,   32'h100);
    chk("post_flush_inst",  id_inst_o, 32'h100 ^ KEY);
    advance();

    // Asynchronous reset mid-stream with three queued entries.
    step(1, 0, 32'h0, 0, 1);
    step(1, 1, 32'h60, 1, 0);
    step(1, 1, 32'h64, 1, 0);
    step(1, 1, 32'h68, 1, 0);
    step(1, 0, 32'h6C, 1, 0);
    @(negedge clk);
    #2;
    ce_i = 1'b1;
    rst  = 1'b0;
    #1;
    chk("rst_valid",  32'(id_valid_o), 32'h0);
    chk("rst_pc",     id_pc_o,         32'h0);
    chk("rst_inst",   id_inst_o,       32'h0);
    chk("rst_romce",  32'(rom_ce_o),   32'h0);
    chk("rst_stall",  32'(pc_stall_o), 32'h0);
    chk("rst_addr",   rom_addr_o,      32'h0);
    q.delete(); m_inf = 0; m_inf_pc = '0;
    step(0, 1, 32'h0, 0, 0);
    step(1, 1, 32'h0, 0, 0);
    step(1, 1, 32'h4, 0, 0);
    drive(1, 1, 32'h8, 0, 0);
    chk("rel_valid", 32'(id_valid_o), 32'h1);
    chk("rel_pc",    id_pc_o,         32'h0);
    advance();

    // Random traffic against the model.
    pc = 32'hC;
    for (int k = 0; k < 400; k++) begin
      bit ce, st, fl;
      ce = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 9) < 4);
      fl = ($urandom_range(0, 19) == 0);
      step(1, ce, pc, st, fl);
      if (fl) pc = $urandom & 32'hFFFF_FFFC;
      else if (e_ce) pc += 4;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Instruction-fetch stage that sits directly downstream of the PC register. It takes the PC stage's fetch address and chip-enable, issues reads to a synchronous instruction ROM, and buffers the returned {pc, inst} pairs in a small in-order queue. It presents instructions to the ID stage with a valid/stall handshake and back-pressures the PC stage when no buffer credit remains. It also supports a pipeline flush that discards all queued and in-flight fetches.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
ADDR_W, 32, instruction address width (matches `InstAddrBus)
DATA_W, 32, instruction word width (matches `InstBus)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
pc_i  input  ADDR_W  fetch address from PC stage
ce_i  input  1  PC-stage chip enable; fetch requested when `ChipEnable
pc_stall_o  output  1  PC stage must hold pc_i this cycle
rom_ce_o  output  1  instruction ROM read enable
rom_addr_o  output  ADDR_W  ROM address; equals pc_i
rom_data_i  input  DATA_W  ROM read data, valid exactly 1 cycle after rom_ce_o=1
id_stall_i  input  1  ID stage not accepting this cycle
flush_i  input  1  synchronous flush from control
id_valid_o  output  1  head entry valid to ID
id_pc_o  output  ADDR_W  head entry pc; 0 when id_valid_o=0
id_inst_o  output  DATA_W  head entry instruction; 0 when id_valid_o=0

Behaviour:
- State: wr_ptr, rd_ptr (log2 DEPTH bits, wrap modulo DEPTH); count (0..DEPTH); inflight flag plus inflight_pc register.
- Credit: space = (count + inflight) < DEPTH. Pop lookahead is not used, so pc_stall_o never depends combinationally on id_stall_i.
- Issue (combinational): rom_ce_o = ce_i & space & ~flush_i; rom_addr_o = pc_i.
- pc_stall_o = ce_i & ~space & ~flush_i.
- On an edge where rom_ce_o=1: inflight<=1, inflight_pc<=pc_i. Otherwise inflight<=0.
- Push: when inflight=1 and flush_i=0, write {inflight_pc, rom_data_i} at wr_ptr, then wr_ptr++.
- Pop: when id_valid_o=1 and id_stall_i=0, rd_ptr++ on the edge.
- id_valid_o = (count != 0) & ~flush_i. id_pc_o/id_inst_o are read from the head entry and forced to 0 when not valid.
- Simultaneous push and pop: count unchanged, both pointers advance. A push into an empty queue is visible the next cycle; there is no bypass.
- Latency: request accepted in cycle N; ROM data arrives in cycle N+1; entry is visible to ID in cycle N+2.
- Throughput: 1 instr/cycle sustained when id_stall_i=0 (steady state count=1, inflight=1).
- Full: count+inflight=DEPTH gives rom_ce_o=0 and pc_stall_o=ce_i.
- Empty: id_valid_o=0.
- ce_i=0: no issue and no stall; a bubble appears in the queue stream.
- Flush (flush_i=1 at an edge): count, wr_ptr, rd_ptr and inflight are all cleared. Any ROM data returning in the next cycle is dropped because inflight=0. During the flush cycle rom_ce_o=0 and id_valid_o=0. The first fetch after a flush is the pc_i presented in the cycle after flush_i deasserts.
- Reset (rst=0, async, any time): pointers, count, inflight, inflight_pc and storage all go to 0. All outputs are 0 while rst=0, including rom_ce_o and pc_stall_o. Operation resumes on the first edge after release.

Decomposition:
- Shared defines file: `InstAddrBus, `InstBus, `ChipEnable/`ChipDisable.
- Add `RstnEnable 1'b0 for the active-low reset.
- Add `ZeroWord 32'h00000000.
- One sub-module: if_queue_ram, a DEPTH x (ADDR_W+DATA_W) register array with one write port and async read at rd_ptr, reset to 0.
- Pointer, count and inflight control stay in inst_fetch_queue.

Test Plan:
1. Assert rst=0 mid-stream with count=3 -> same cycle all outputs 0. After release with ce_i=1, pc_i=0: id_valid_o=1 two cycles later with id_pc_o=0x0.
2. Stream pc 0x0,0x4,0x8,… with ce_i=1, id_stall_i=0, ROM returning inst=pc^0xA5A5A5A5 -> id_valid_o rises at cycle 2 and stays high. id_pc_o increments by 4 each cycle and id_inst_o matches. pc_stall_o stays 0.
3. Hold id_stall_i=1 while streaming -> after 4 accepted requests pc_stall_o=1 and rom_ce_o=0. Release id_stall_i -> entries drain in order 0x0..0xC, then fetching resumes at 0x10 with no loss and no duplicates.
4. Pulse flush_i with 2 queued entries and 1 in flight, then present pc_i=0x100 -> id_valid_o=0 in the flush cycle and the next cycle. The next ID instruction is 0x100 and the returning in-flight data is never presented.
5. Keep the queue full with id_stall_i toggling 0/1 each cycle -> count never exceeds DEPTH. A pop and an issue can occur on alternate cycles with correct order.
6. Toggle ce_i 1,0,1,0 with pc_i 0x20,0x20,0x24,0x24 -> exactly two entries (0x20, 0x24) reach ID, with a one-cycle gap between them.
